// File: rtl/tx_fifo_arb.sv
// Round-robin arbiter sharing the TX FIFO write port between two word sources.
// Bounded bursts per grant, stalls on FIFO-full, no idle bubble on hand-over.
//
// state | meaning
// IDLE  | no owner, arbitrate on the next valid requester(s)
// GNT0  | requester 0 owns the FIFO write port
// GNT1  | requester 1 owns the FIFO write port
module tx_fifo_arb #(
    parameter int DW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [DW-1:0] tx_fifo_data,
    input  logic          tx_fifo_full,
    output logic          tx_fifo_en,
    output logic [1:0]    grant,
    output logic [7:0]    burst_cnt
);

    // State codes double as the one-hot grant vector.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic [7:0] cnt_nxt;
    logic       own0;
    logic       own1;
    logic       xfer0;
    logic       xfer1;

    assign own0 = (state == GNT0);
    assign own1 = (state == GNT1);

    assign req0_ready   = own0 && !tx_fifo_full;
    assign req1_ready   = own1 && !tx_fifo_full;
    assign xfer0        = req0_valid && req0_ready;
    assign xfer1        = req1_valid && req1_ready;
    assign tx_fifo_en   = xfer0 || xfer1;
    assign tx_fifo_data = own0 ? req0_data : (own1 ? req1_data : '0);
    assign grant        = state;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = burst_cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0_valid && req1_valid)
                    state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0_valid)
                    state_nxt = GNT0;
                else if (req1_valid)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if ((xfer0 && burst_cnt == LAST_CNT) || !req0_valid) begin
                    last_grant_nxt = 1'b0;
                    cnt_nxt        = '0;
                    if (req1_valid)
                        state_nxt = GNT1;
                    else if (req0_valid)
                        state_nxt = GNT0;
                    else
                        state_nxt = IDLE;
                end else if (xfer0) begin
                    cnt_nxt = burst_cnt + 8'd1;
                end
            end
            GNT1: begin
                if ((xfer1 && burst_cnt == LAST_CNT) || !req1_valid) begin
                    last_grant_nxt = 1'b1;
                    cnt_nxt        = '0;
                    if (req0_valid)
                        state_nxt = GNT0;
                    else if (req1_valid)
                        state_nxt = GNT1;
                    else
                        state_nxt = IDLE;
                end else if (xfer1) begin
                    cnt_nxt = burst_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            burst_cnt  <= cnt_nxt;
        end
    end

endmodule
